ws2812_frame_driver: RTL and testbench

- Read-side consumer of the 8x8 cell grid. Once per frame tick it scans all 64 pixel addresses and samples the 8-bit `read_data`.
- Each cell is expanded to a 24-bit GRB word and serialised onto a WS2812 LED chain.
- After the latch gap it emits a one-cycle `newframe` pulse, so the grid advances one generation only between scans. This gives tear-free display.

---
 rtl/ws2812_frame_driver_if.sv | 28 ++
 rtl/ws2812_frame_driver.sv | 127 ++++++++++++
 tb/tb_ws2812_frame_driver.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_frame_driver_if.sv
// Grid-scan and LED-chain signals of the frame driver.
// master = driver side, slave = grid/system side.
interface ws2812_frame_driver_if;
  logic       enable;
  logic [5:0] pixel;
  logic [7:0] read_data;
  logic       newframe;
  logic       led_dout;
  logic       busy;

  modport master (
    input  enable,
    input  read_data,
    output pixel,
    output newframe,
    output led_dout,
    output busy
  );

  modport slave (
    output enable,
    output read_data,
    input  pixel,
    input  newframe,
    input  led_dout,
    input  busy
  );
endinterface

// File: rtl/ws2812_frame_driver.sv
// Scans the 8x8 grid once per frame tick, serialises each cell as a 24-bit GRB word
// onto a WS2812 chain, then latches and pulses newframe so the grid advances between scans.
module ws2812_frame_driver #(
  parameter int unsigned FRAME_CYCLES = 1200000,
  parameter int unsigned TBIT         = 15,
  parameter int unsigned T0H          = 4,
  parameter int unsigned T1H          = 8,
  parameter int unsigned TRESET       = 1000,
  parameter logic [7:0]  G_MASK       = 8'hFF,
  parameter logic [7:0]  R_MASK       = 8'h00,
  parameter logic [7:0]  B_MASK       = 8'h00,
  parameter int unsigned SERPENTINE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  ws2812_frame_driver_if.master bus
);

  localparam int unsigned TW = $clog2(FRAME_CYCLES);
  localparam int unsigned CW = $clog2(((TRESET > TBIT) ? TRESET : TBIT) + 1);

  typedef enum logic [2:0] {StIdle, StFetch, StSend, StLatch, StDone} state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [5:0]     idx_q, idx_d;
  logic [5:0]     pixel_q, pixel_d;
  logic [4:0]     bit_q, bit_d;
  logic [23:0]    shift_q, shift_d;
  logic           tick;

  function automatic logic [5:0] map_pixel(input logic [5:0] idx);
    if ((SERPENTINE != 0) && idx[3]) return {idx[5:3], ~idx[2:0]};
    return idx;
  endfunction

  assign tick = (timer_q == TW'(FRAME_CYCLES - 1));

  // Free-running frame timer; independent of the FSM so overruns simply skip ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_q <= '0;
    else     timer_q <= tick ? '0 : timer_q + TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      pixel_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pixel_q <= pixel_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pixel_d = pixel_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        if (tick && bus.enable) begin
          idx_d   = '0;
          pixel_d = map_pixel(6'd0);
          state_d = StFetch;
        end
      end
      StFetch: begin
        shift_d = {bus.read_data & G_MASK, bus.read_data & R_MASK, bus.read_data & B_MASK};
        bit_d   = 5'd23;
        cnt_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        if (cnt_q == CW'(TBIT - 1)) begin
          cnt_d = '0;
          if (bit_q == 5'd0) begin
            if (idx_q == 6'd63) begin
              state_d = StLatch;
            end else begin
              idx_d   = idx_q + 6'd1;
              pixel_d = map_pixel(idx_q + 6'd1);
              state_d = StFetch;
            end
          end else begin
            bit_d   = bit_q - 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StLatch: begin
        if (cnt_q == CW'(TRESET - 1)) state_d = StDone;
        else                          cnt_d   = cnt_q + CW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic led, busy, newframe;

  always_comb begin
    led      = (state_q == StSend) &&
               (cnt_q < (shift_q[23] ? CW'(T1H) : CW'(T0H)));
    busy     = (state_q != StIdle);
    newframe = (state_q == StDone);
  end

  assign bus.led_dout = led;
  assign bus.busy     = busy;
  assign bus.newframe = newframe;
  assign bus.pixel    = pixel_q;

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Self-checking bench: four driver instances on one clock cover idle timing, bit encoding,
// address order, enable control, async reset and overrun with a per-frame word scoreboard.
module tb_ws2812_frame_driver;

  localparam int TB_TBIT   = 15;
  localparam int TB_T0H    = 4;
  localparam int TB_T1H    = 8;
  localparam int TB_TRESET = 20;
  localparam logic [7:0] TB_G = 8'hFF;
  localparam logic [7:0] TB_R = 8'h00;
  localparam logic [7:0] TB_B = 8'h00;

  logic       clk;
  logic [3:0] rst_v;
  logic [3:0] en_v;
  logic [3:0] led_v, busy_v, nf_v;
  logic [5:0] pix_v [4];
  int         grid_mode [4];
  int         nf_cnt [4];
  time        rel_t [4];
  int         errors = 0;
  int         checks = 0;

  ws2812_frame_driver_if bus0 ();
  ws2812_frame_driver_if bus1 ();
  ws2812_frame_driver_if bus2 ();
  ws2812_frame_driver_if bus3 ();

  function automatic logic [7:0] grid(input int mode, input logic [5:0] p);
    if (mode == 0) return 8'hFF;
    return (p == 6'd9) ? 8'hFF : 8'h00;
  endfunction

  function automatic logic [5:0] exp_pixel(input int i, input int serp);
    int row, col;
    row = i / 8;
    col = i % 8;
    if (serp != 0 && (row % 2) == 1) col = 7 - col;
    return 6'(row * 8 + col);
  endfunction

  function automatic logic [23:0] exp_word(input logic [7:0] rd);
    return {rd & TB_G, rd & TB_R, rd & TB_B};
  endfunction

  assign bus0.enable = en_v[0];
  assign bus1.enable = en_v[1];
  assign bus2.enable = en_v[2];
  assign bus3.enable = en_v[3];
  assign bus0.read_data = grid(grid_mode[0], bus0.pixel);
  assign bus1.read_data = grid(grid_mode[1], bus1.pixel);
  assign bus2.read_data = grid(grid_mode[2], bus2.pixel);
  assign bus3.read_data = grid(grid_mode[3], bus3.pixel);
  assign led_v  = {bus3.led_dout, bus2.led_dout, bus1.led_dout, bus0.led_dout};
  assign busy_v = {bus3.busy, bus2.busy, bus1.busy, bus0.busy};
  assign nf_v   = {bus3.newframe, bus2.newframe, bus1.newframe, bus0.newframe};
  assign pix_v[0] = bus0.pixel;
  assign pix_v[1] = bus1.pixel;
  assign pix_v[2] = bus2.pixel;
  assign pix_v[3] = bus3.pixel;

  ws2812_frame_driver #(.FRAME_CYCLES(30000), .TBIT(TB_TBIT), .T0H(TB_T0H), .T1H(TB_T1H),
    .TRESET(TB_TRESET), .SERPENTINE(0)) dut0 (.clk(clk), .rst(rst_v[0]), .bus(bus0));
  ws2812_frame_driver #(.FRAME_CYCLES(24000), .TBIT(TB_TBIT), .T0H(TB_T0H), .T1H(TB_T1H),
    .TRESET(TB_TRESET), .SERPENTINE(1)) dut1 (.clk(clk), .rst(rst_v[1]), .bus(bus1));
  ws2812_frame_driver #(.FRAME_CYCLES(24000), .TBIT(TB_TBIT), .T0H(TB_T0H), .T1H(TB_T1H),
    .TRESET(TB_TRESET), .SERPENTINE(0)) dut2 (.clk(clk), .rst(rst_v[2]), .bus(bus2));
  ws2812_frame_driver #(.FRAME_CYCLES(15000), .TBIT(TB_TBIT), .T0H(TB_T0H), .T1H(TB_T1H),
    .TRESET(TB_TRESET), .SERPENTINE(0)) dut3 (.clk(clk), .rst(rst_v[3]), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (nf_v[k] === 1'b1) nf_cnt[k]++;
  end

  function automatic int elapsed(input int d);
    return int'(($time - rel_t[d]) / 10);
  endfunction

  // Steps negedges until busy or the budget runs out, noting any activity while idle.
  task automatic wait_busy(input int d, input int budget, output int waited,
                           output bit noisy, output bit pix_moved);
    waited = 0; noisy = 0; pix_moved = 0;
    while (busy_v[d] !== 1'b1 && waited < budget) begin
      if (led_v[d] !== 1'b0 || nf_v[d] !== 1'b0) noisy = 1;
      if (pix_v[d] !== 6'd0) pix_moved = 1;
      @(negedge clk);
      waited++;
    end
  endtask

  // Entered on the FETCH cycle of pixel 0; decodes the frame against the scoreboard.
  task automatic run_frame(input int d, input int serp, input int stop_pixel,
                           input int drop_pixel);
    logic [23:0] exp_q[$];
    logic [23:0] got, want;
    logic [14:0] v, pat0, pat1;
    logic [5:0]  ep;
    bit          shape_bad, bad;
    for (int c = 0; c < TB_TBIT; c++) begin
      pat1[14-c] = (c < TB_T1H);
      pat0[14-c] = (c < TB_T0H);
    end
    for (int i = 0; i < 64; i++) begin
      ep = exp_pixel(i, serp);
      checks++;
      if (pix_v[d] !== ep || led_v[d] !== 1'b0 || busy_v[d] !== 1'b1) begin
        errors++;
        $display("FAIL fetch dut%0d idx%0d: pixel=%0d led=%b busy=%b, want pixel=%0d led=0 busy=1",
                 d, i, pix_v[d], led_v[d], busy_v[d], ep);
      end
      if (i == drop_pixel) en_v[d] = 1'b0;
      exp_q.push_back(exp_word(grid(grid_mode[d], ep)));
      if (i == stop_pixel) return;
      shape_bad = 0;
      got = '0;
      for (int b = 0; b < 24; b++) begin
        for (int c = 0; c < TB_TBIT; c++) begin
          @(negedge clk);
          v[14-c] = led_v[d];
        end
        if (v == pat1)      got[23-b] = 1'b1;
        else if (v == pat0) got[23-b] = 1'b0;
        else                shape_bad = 1;
      end
      want = exp_q.pop_front();
      checks++;
      if (got !== want || shape_bad) begin
        errors++;
        $display("FAIL word dut%0d idx%0d: got %06h (malformed=%0d), want %06h",
                 d, i, got, shape_bad, want);
      end
      @(negedge clk);
    end
    bad = 0;
    for (int c = 0; c < TB_TRESET; c++) begin
      if (led_v[d] !== 1'b0 || busy_v[d] !== 1'b1 || nf_v[d] !== 1'b0) bad = 1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL latch dut%0d: activity in latch gap, want led=0 busy=1 newframe=0", d);
    end
    checks++;
    if (nf_v[d] !== 1'b1 || busy_v[d] !== 1'b1 || led_v[d] !== 1'b0) begin
      errors++;
      $display("FAIL pulse dut%0d: newframe=%b busy=%b led=%b, want 1 1 0",
               d, nf_v[d], busy_v[d], led_v[d]);
    end
    @(negedge clk);
    checks++;
    if (nf_v[d] !== 1'b0 || busy_v[d] !== 1'b0) begin
      errors++;
      $display("FAIL end dut%0d: newframe=%b busy=%b, want 0 0", d, nf_v[d], busy_v[d]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic test_reset;
    rst_v = 4'hF;
    en_v  = 4'b1011;
    grid_mode[0] = 0; grid_mode[1] = 1; grid_mode[2] = 0; grid_mode[3] = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (led_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || nf_v[d] !== 1'b0 || pix_v[d] !== 6'd0) begin
        errors++;
        $display("FAIL reset dut%0d: led=%b busy=%b newframe=%b pixel=%0d, want all 0",
                 d, led_v[d], busy_v[d], nf_v[d], pix_v[d]);
      end
    end
    rst_v = 4'h0;
    for (int d = 0; d < 4; d++) rel_t[d] = $time;
  endtask

  task automatic test_idle_first_tick;
    int w; bit noisy, pm;
    wait_busy(0, 30100, w, noisy, pm);
    check_int("first_tick_start", elapsed(0), 30000);
    check_int("idle_quiet", int'(noisy) + int'(pm), 0);
  endtask

  task automatic test_bit_encoding;
    run_frame(0, 0, -1, -1);
    check_int("bitenc_newframes", nf_cnt[0], 1);
  endtask

  task automatic test_address_linear;
    int w; bit noisy, pm;
    grid_mode[0] = 1;
    wait_busy(0, 10000, w, noisy, pm);
    check_int("linear_start", elapsed(0), 60000);
    run_frame(0, 0, -1, -1);
    check_int("linear_newframes", nf_cnt[0], 2);
  endtask

  task automatic test_address_serpentine;
    int w; bit noisy, pm;
    wait_busy(1, 24100, w, noisy, pm);
    check_int("serp_start", elapsed(1), 24000);
    run_frame(1, 1, -1, -1);
    check_int("serp_newframes", nf_cnt[1], 1);
  endtask

  task automatic test_async_reset;
    int w, n0; bit noisy, pm;
    grid_mode[1] = 0;
    wait_busy(1, 2000, w, noisy, pm);
    check_int("async_frame_start", elapsed(1), 48000);
    run_frame(1, 1, 10, -1);
    repeat (1 + 5 * TB_TBIT) @(negedge clk);
    check_int("async_pre_high", int'(led_v[1]), 1);
    #1 rst_v[1] = 1'b1;
    #1;
    checks++;
    if (led_v[1] !== 1'b0 || busy_v[1] !== 1'b0 || pix_v[1] !== 6'd0) begin
      errors++;
      $display("FAIL async_drop: led=%b busy=%b pixel=%0d, want 0 0 0",
               led_v[1], busy_v[1], pix_v[1]);
    end
    n0 = nf_cnt[1];
    repeat (2) @(negedge clk);
    rst_v[1] = 1'b0;
    rel_t[1] = $time;
    wait_busy(1, 24100, w, noisy, pm);
    check_int("async_restart", elapsed(1), 24000);
    check_int("async_quiet", int'(noisy) + int'(pm), 0);
    check_int("async_no_newframe", nf_cnt[1], n0);
    run_frame(1, 1, 2, -1);
  endtask

  task automatic test_enable;
    int w; bit noisy, pm;
    wait_busy(2, 24100, w, noisy, pm);
    check_int("disabled_no_scan", w, 24100);
    check_int("disabled_no_newframe", nf_cnt[2], 0);
    en_v[2] = 1'b1;
    wait_busy(2, 25000, w, noisy, pm);
    check_int("enabled_start", elapsed(2), 48000);
    run_frame(2, 0, -1, 30);
    check_int("drop_one_newframe", nf_cnt[2], 1);
    wait_busy(2, 3000, w, noisy, pm);
    check_int("dropped_no_scan", w, 3000);
    check_int("dropped_newframes", nf_cnt[2], 1);
  endtask

  task automatic test_overrun;
    int w; bit noisy, pm;
    wait_busy(3, 15100, w, noisy, pm);
    check_int("overrun_start1", elapsed(3), 15000);
    run_frame(3, 0, -1, -1);
    wait_busy(3, 10000, w, noisy, pm);
    check_int("overrun_start2", elapsed(3), 45000);
    run_frame(3, 0, -1, -1);
    wait_busy(3, 10000, w, noisy, pm);
    check_int("overrun_start3", elapsed(3), 75000);
    check_int("overrun_newframes", nf_cnt[3], 2);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) nf_cnt[k] = 0;
    test_reset();
    fork
      begin
        test_idle_first_tick();
        test_bit_encoding();
        test_address_linear();
      end
      begin
        test_address_serpentine();
        test_async_reset();
      end
      test_enable();
      test_overrun();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
